module_bin_to_bcd_seq: RTL and testbench
========================================

// Module: module_bin_to_bcd_seq
// PURPOSE
//  Sequential double-dabble converter. Turns a WIDTH-bit unsigned binary value into DIGITS packed BCD digits.
//  Start/valid handshake; one shift per clock. Feeds the 7-segment display path and any downstream BCD consumer.
//  Generalises the fixed 4-bit/2-digit converter: arbitrary width and digit count, plus busy, abort and overflow.
// PARAMETERS
//  WIDTH   12  binary input width, >= 1
//  DIGITS  4   BCD digits produced, >= 1; bcd_o is 4*DIGITS bits
// PORTS
//  clk_i       in   1          clock, rising edge
//  rst_i       in   1          asynchronous, active-high reset
//  start_i     in   1          request conversion of bin_i; honoured only in IDLE
//  abort_i     in   1          synchronous cancel of a running conversion
//  bin_i       in   WIDTH      unsigned value, sampled on the accepting edge only
//  busy_o      out  1          high while state != IDLE
//  valid_o     out  1          one-cycle pulse: bcd_o/overflow_o updated
//  bcd_o       out  4*DIGITS   digit k at [4k+3:4k], k=0 is units; holds last result
//  overflow_o  out  1          last result truncated (bin >= 10^DIGITS); held with bcd_o
// BEHAVIOUR
//  Reset (async, any time, including mid-conversion):
//   - state=IDLE; busy_o=0, valid_o=0, bcd_o=0, overflow_o=0
//   - internal shift register, digit register and counter cleared
//  FSM: IDLE -> CONV -> DONE -> IDLE
//   IDLE:
//    - start_i=1 at edge E0: capture bin_i into shift reg, clear digit reg and sticky ovf, cnt=WIDTH, go CONV
//   CONV, one step per edge E1..E_WIDTH:
//    - every digit >4 gets +3 (4-bit, all digits in parallel, combinational)
//    - then {digits,shift} shift left 1; bit leaving top digit ORs into sticky ovf
//    - cnt decrements; the step with cnt==1 goes to DONE
//   DONE at edge E_{WIDTH+1}:
//    - bcd_o<=digits, overflow_o<=ovf, valid_o<=1, go IDLE
//    - valid_o clears at next edge
//  Latency: valid_o high in the cycle after E_{WIDTH+1}.
//   Earliest next accept at E_{WIDTH+2} (start_i held high -> back-to-back).
//  start_i while busy_o=1: ignored, no queuing; bin_i changes while busy: no effect.
//  abort_i=1 in CONV or DONE: next edge goes IDLE.
//   - valid_o stays 0; bcd_o and overflow_o keep their previous values
//   - abort has priority over the DONE update
//  abort_i in IDLE: no effect; start_i is still honoured that same edge.
//  Overflow: bcd_o holds value mod 10^DIGITS, overflow_o=1. DIGITS >= ceil(WIDTH*log10 2) never overflows.
//  WIDTH=1: CONV lasts one edge. Counter width $clog2(WIDTH+1).
// TESTING
//  1 W=12,D=4: start, bin=0 -> valid_o at E13, bcd_o=16'h0000, ovf=0
//  2 W=12,D=4: bin=4095 -> bcd_o=16'h4095; bin=999 -> 16'h0999; busy_o high E0..E13 exactly
//  3 W=10,D=3: bin=1000 -> bcd_o=12'h000, ovf=1; next bin=999 -> 12'h999, ovf=0
//  4 start held high, bins 1234, 56 -> two valid pulses 14 cycles apart, 16'h1234, then 16'h0056;
//    start pulses mid-conversion ignored
//  5 abort_i at E5 of bin=321 after prior result 16'h0042 -> no valid_o, bcd_o stays 16'h0042, busy_o low;
//    new start converts correctly
//  6 rst_i asserted between edges mid-CONV -> all outputs 0 immediately; random sweep vs reference model

Source files
------------

// File: rtl/module_bin_to_bcd_seq_if.sv
// Start/valid handshake bundle for the sequential binary-to-BCD converter.
// The master drives requests; the slave (the converter) returns status and results.
interface module_bin_to_bcd_seq_if #(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 4
);
  logic                  start_i;
  logic                  abort_i;
  logic [WIDTH-1:0]      bin_i;
  logic                  busy_o;
  logic                  valid_o;
  logic [4*DIGITS-1:0]   bcd_o;
  logic                  overflow_o;

  modport master (
    output start_i, abort_i, bin_i,
    input  busy_o, valid_o, bcd_o, overflow_o
  );

  modport slave (
    input  start_i, abort_i, bin_i,
    output busy_o, valid_o, bcd_o, overflow_o
  );
endinterface

// File: rtl/module_bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, WIDTH-bit binary to DIGITS packed BCD digits.
// Result and overflow flag are held until the next completed conversion; abort cancels without updating them.
module module_bin_to_bcd_seq #(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 4
) (
  input logic                     clk_i,
  input logic                     rst_i,
  module_bin_to_bcd_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]   digits_q, digits_d;
  logic [BW-1:0]   adj;
  logic            ovf_q, ovf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            overflow_q, overflow_d;
  logic            valid_q, valid_d;

  // Add-3 correction on every digit in parallel before the shift.
  always_comb begin
    adj = digits_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (digits_q[4*k +: 4] > 4'd4) adj[4*k +: 4] = digits_q[4*k +: 4] + 4'd3;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    digits_d   = digits_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          shift_d  = bus.bin_i;
          digits_d = '0;
          ovf_d    = 1'b0;
          cnt_d    = CW'(WIDTH);
          state_d  = S_CONV;
        end
      end
      S_CONV: begin
        if (bus.abort_i) begin
          state_d = S_IDLE;
        end else begin
          // The bit shifted out of the top digit carries weight 10^DIGITS; dropping it keeps value mod 10^DIGITS.
          digits_d = {adj[BW-2:0], shift_q[WIDTH-1]};
          shift_d  = shift_q << 1;
          ovf_d    = ovf_q | adj[BW-1];
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!bus.abort_i) begin
          bcd_d      = digits_q;
          overflow_d = ovf_q;
          valid_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      digits_q   <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      digits_q   <= digits_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.busy_o     = (state_q != S_IDLE);
  assign bus.valid_o    = valid_q;
  assign bus.bcd_o      = bcd_q;
  assign bus.overflow_o = overflow_q;
endmodule

// File: tb/tb_module_bin_to_bcd_seq.sv
// Self-checking bench for module_bin_to_bcd_seq: directed scenarios plus a random sweep
// against a decimal-arithmetic reference, on a 12-bit/4-digit and a 10-bit/3-digit instance.
module tb_module_bin_to_bcd_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  module_bin_to_bcd_seq_if #(.WIDTH(12), .DIGITS(4)) a_if ();
  module_bin_to_bcd_seq_if #(.WIDTH(10), .DIGITS(3)) b_if ();

  module_bin_to_bcd_seq #(.WIDTH(12), .DIGITS(4)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (a_if)
  );

  module_bin_to_bcd_seq #(.WIDTH(10), .DIGITS(3)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b_if)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: decimal digits of v, truncated to the lowest 'digits' positions.
  function automatic logic [63:0] ref_bcd(input int unsigned v, input int digits);
    logic [63:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int k = 0; k < digits; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int unsigned v, input int digits);
    int unsigned p;
    p = 1;
    for (int k = 0; k < digits; k++) p = p * 10;
    return (v >= p);
  endfunction

  task automatic run_a(input int unsigned v, input logic abort_with_start);
    int n;
    int busy_n;
    a_if.bin_i   = 12'(v);
    a_if.start_i = 1'b1;
    a_if.abort_i = abort_with_start;
    tick();
    a_if.start_i = 1'b0;
    a_if.abort_i = 1'b0;
    n = 0;
    busy_n = 0;
    while (!a_if.valid_o && n < 40) begin
      if (a_if.busy_o) busy_n++;
      tick();
      n++;
    end
    check("a_latency", 64'(n), 64'd13);
    check("a_busy_cycles", 64'(busy_n), 64'd13);
    check("a_busy_at_valid", 64'(a_if.busy_o), 64'd0);
    check("a_bcd", 64'(a_if.bcd_o), ref_bcd(v, 4));
    check("a_ovf", 64'(a_if.overflow_o), 64'(ref_ovf(v, 4)));
    tick();
    check("a_valid_one_cycle", 64'(a_if.valid_o), 64'd0);
  endtask

  task automatic run_b(input int unsigned v);
    int n;
    b_if.bin_i   = 10'(v);
    b_if.start_i = 1'b1;
    tick();
    b_if.start_i = 1'b0;
    n = 0;
    while (!b_if.valid_o && n < 40) begin
      tick();
      n++;
    end
    check("b_latency", 64'(n), 64'd11);
    check("b_bcd", 64'(b_if.bcd_o), ref_bcd(v, 3));
    check("b_ovf", 64'(b_if.overflow_o), 64'(ref_ovf(v, 3)));
    tick();
  endtask

  initial begin
    int n;
    int seen;
    int unsigned v;

    a_if.start_i = 1'b0; a_if.abort_i = 1'b0; a_if.bin_i = '0;
    b_if.start_i = 1'b0; b_if.abort_i = 1'b0; b_if.bin_i = '0;

    // Reset state
    #1;
    check("rst_a_busy", 64'(a_if.busy_o), 64'd0);
    check("rst_a_valid", 64'(a_if.valid_o), 64'd0);
    check("rst_a_bcd", 64'(a_if.bcd_o), 64'd0);
    check("rst_a_ovf", 64'(a_if.overflow_o), 64'd0);
    check("rst_b_bcd", 64'(b_if.bcd_o), 64'd0);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 1, 2: zero, full scale, 999, with latency and busy window
    run_a(0, 1'b0);
    run_a(4095, 1'b0);
    run_a(999, 1'b0);

    // 3: overflow on the 3-digit instance, then a clean result clears the flag
    run_b(1000);
    run_b(999);

    // 4: start held high -> back-to-back; bin_i changes while busy are ignored
    a_if.bin_i   = 12'd1234;
    a_if.start_i = 1'b1;
    tick();
    a_if.bin_i = 12'd56;
    n = 0;
    while (!a_if.valid_o && n < 40) begin
      tick();
      n++;
    end
    check("b2b_first_latency", 64'(n), 64'd13);
    check("b2b_first_bcd", 64'(a_if.bcd_o), 64'h1234);
    tick();
    n = 1;
    while (!a_if.valid_o && n < 40) begin
      a_if.start_i = n[0];
      tick();
      n++;
    end
    a_if.start_i = 1'b0;
    check("b2b_spacing", 64'(n), 64'd14);
    check("b2b_second_bcd", 64'(a_if.bcd_o), 64'h0056);
    check("b2b_second_ovf", 64'(a_if.overflow_o), 64'd0);
    tick();

    // 5: abort mid-conversion keeps the previous result
    run_a(42, 1'b0);
    a_if.bin_i   = 12'd321;
    a_if.start_i = 1'b1;
    tick();
    a_if.start_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    a_if.abort_i = 1'b1;
    tick();
    a_if.abort_i = 1'b0;
    check("abort_busy", 64'(a_if.busy_o), 64'd0);
    check("abort_valid", 64'(a_if.valid_o), 64'd0);
    check("abort_bcd_held", 64'(a_if.bcd_o), 64'h0042);
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (a_if.valid_o) seen++;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    run_a(321, 1'b0);

    // Abort in DONE wins over the result update
    a_if.bin_i   = 12'd77;
    a_if.start_i = 1'b1;
    tick();
    a_if.start_i = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    a_if.abort_i = 1'b1;
    tick();
    a_if.abort_i = 1'b0;
    check("abort_done_valid", 64'(a_if.valid_o), 64'd0);
    check("abort_done_bcd_held", 64'(a_if.bcd_o), 64'h0321);
    check("abort_done_busy", 64'(a_if.busy_o), 64'd0);
    tick();

    // Abort in IDLE does not block a same-edge start
    run_a(555, 1'b1);

    // 6: asynchronous reset between edges mid-conversion
    a_if.bin_i   = 12'd2048;
    a_if.start_i = 1'b1;
    tick();
    a_if.start_i = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(a_if.busy_o), 64'd0);
    check("async_rst_valid", 64'(a_if.valid_o), 64'd0);
    check("async_rst_bcd", 64'(a_if.bcd_o), 64'd0);
    check("async_rst_ovf", 64'(a_if.overflow_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Random sweep against the reference
    for (int i = 0; i < 20; i++) begin
      v = $urandom_range(0, 4095);
      run_a(v, 1'b0);
    end
    for (int i = 0; i < 12; i++) begin
      v = $urandom_range(0, 1023);
      run_b(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
